// File: rtl/ifu_fetch.sv
// ifu_fetch: RV64 instruction fetch stage.
// Holds the architectural PC and keeps at most one instruction-memory request
// outstanding. Each returned word is registered and offered to decode over a
// valid/ready handshake. A redirect retargets the PC. Any fetch that is in
// flight when the redirect arrives is marked killed, and its response is dropped.
module ifu_fetch #(
    parameter int               XLEN     = 64,
    parameter logic [XLEN-1:0]  RESET_PC = 64'h8000_0000
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [XLEN-1:0]   imem_req_addr,
    input  logic              imem_resp_valid,
    input  logic [31:0]       imem_resp_data,
    output logic              id_valid,
    input  logic              id_ready,
    output logic [31:0]       id_inst,
    output logic [XLEN-1:0]   id_pc,
    input  logic              redirect_valid,
    input  logic [XLEN-1:0]   redirect_pc,
    output logic [63:0]       fetch_cnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_OUT  = 2'd3
    } state_t;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    state_t            r_state;
    logic [XLEN-1:0]   r_pc;
    logic [XLEN-1:0]   r_reqAddr;
    logic [31:0]       r_idInst;
    logic [XLEN-1:0]   r_idPc;
    logic              r_kill;
    logic [63:0]       r_fetchCnt;

    state_t            w_stateNext;
    logic [XLEN-1:0]   w_pcNext;
    logic [XLEN-1:0]   w_reqAddrNext;
    logic [31:0]       w_idInstNext;
    logic [XLEN-1:0]   w_idPcNext;
    logic              w_killNext;
    logic [63:0]       w_fetchCntNext;

    logic [XLEN-1:0]   w_redirTarget;
    logic [XLEN-1:0]   w_pcPlus4;

    assign w_redirTarget = {redirect_pc[XLEN-1:2], 2'b00};
    assign w_pcPlus4     = r_pc + XLEN'(4);

    // Next-state and next-register logic. A redirect always wins the PC.
    always_comb begin
        w_stateNext    = r_state;
        w_pcNext       = r_pc;
        w_reqAddrNext  = r_reqAddr;
        w_idInstNext   = r_idInst;
        w_idPcNext     = r_idPc;
        w_killNext     = r_kill;
        w_fetchCntNext = r_fetchCnt;

        if (redirect_valid) begin
            w_pcNext = w_redirTarget;
        end

        case (r_state)
            S_IDLE: begin
                w_stateNext   = S_REQ;
                w_reqAddrNext = redirect_valid ? w_redirTarget : r_pc;
            end
            S_REQ: begin
                // The presented address must stay put until it is accepted,
                // so a redirect can only condemn the response of this fetch.
                if (redirect_valid) begin
                    w_killNext = 1'b1;
                end
                if (imem_req_ready) begin
                    w_stateNext = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_resp_valid) begin
                    if (redirect_valid) begin
                        w_killNext    = 1'b0;
                        w_reqAddrNext = w_redirTarget;
                        w_stateNext   = S_REQ;
                    end else if (r_kill) begin
                        w_killNext    = 1'b0;
                        w_reqAddrNext = r_pc;
                        w_stateNext   = S_REQ;
                    end else begin
                        w_idInstNext = imem_resp_data;
                        w_idPcNext   = r_reqAddr;
                        w_stateNext  = S_OUT;
                    end
                end else if (redirect_valid) begin
                    w_killNext = 1'b1;
                end
            end
            S_OUT: begin
                if (redirect_valid) begin
                    // Any instruction that decode takes in this cycle still counts.
                    // The next fetch always starts at the redirect target.
                    w_reqAddrNext = w_redirTarget;
                    w_stateNext   = S_REQ;
                    if (id_ready) begin
                        w_fetchCntNext = r_fetchCnt + 64'd1;
                    end
                end else if (id_ready) begin
                    w_pcNext       = w_pcPlus4;
                    w_reqAddrNext  = w_pcPlus4;
                    w_fetchCntNext = r_fetchCnt + 64'd1;
                    w_stateNext    = S_REQ;
                end
            end
            default: begin
                w_stateNext = S_IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_pc       <= RESET_PC;
            r_reqAddr  <= RESET_PC;
            r_idInst   <= NOP_INST;
            r_idPc     <= RESET_PC;
            r_kill     <= 1'b0;
            r_fetchCnt <= 64'd0;
        end else begin
            r_state    <= w_stateNext;
            r_pc       <= w_pcNext;
            r_reqAddr  <= w_reqAddrNext;
            r_idInst   <= w_idInstNext;
            r_idPc     <= w_idPcNext;
            r_kill     <= w_killNext;
            r_fetchCnt <= w_fetchCntNext;
        end
    end

    assign imem_req_valid = (r_state == S_REQ);
    assign imem_req_addr  = r_reqAddr;
    assign id_valid       = (r_state == S_OUT);
    assign id_inst        = r_idInst;
    assign id_pc          = r_idPc;
    assign fetch_cnt      = r_fetchCnt;

endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch: self-checking bench for ifu_fetch.
// The bench has three parts. A per-cycle vector table covers the basic fetch
// stream and the redirect-in-OUT cases. Hand-written sequences cover the stall,
// kill and reset corner cases. A randomized phase checks the delivered
// instruction stream against a program-order model.
module tb_ifu_fetch;

    localparam logic [63:0] RST_PC = 64'h8000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [63:0] imem_req_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = 32'h0;
    logic        id_valid;
    logic        id_ready = 1'b0;
    logic [31:0] id_inst;
    logic [63:0] id_pc;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = 64'h0;
    logic [63:0] fetch_cnt;

    int assertCount = 0;
    int failCount   = 0;

    ifu_fetch #(.XLEN(64), .RESET_PC(64'h8000_0000)) dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .id_valid        (id_valid),
        .id_ready        (id_ready),
        .id_inst         (id_inst),
        .id_pc           (id_pc),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .fetch_cnt       (fetch_cnt)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    typedef struct {
        logic        rr;
        logic        respV;
        logic [31:0] respD;
        logic        idr;
        logic        redV;
        logic [63:0] redPc;
        logic        expReqV;
        logic [63:0] expAddr;
        logic        expIdV;
        logic [31:0] expInst;
        logic [63:0] expPc;
        logic [63:0] expCnt;
    } vec_t;

    vec_t vecs[17];

    function automatic logic [31:0] instFor(input logic [63:0] a);
        return {a[17:2], a[17:2]} ^ 32'hC3A5_0F13;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        assertCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic rr, input logic respV, input logic [31:0] respD,
                                 input logic idr, input logic redV, input logic [63:0] redPc);
        imem_req_ready  = rr;
        imem_resp_valid = respV;
        imem_resp_data  = respD;
        id_ready        = idr;
        redirect_valid  = redV;
        redirect_pc     = redPc;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic checkAll(input string tag, input logic eReqV, input logic [63:0] eAddr,
                            input logic eIdV, input logic [31:0] eInst, input logic [63:0] ePc,
                            input logic [63:0] eCnt);
        checkOutput({tag, " req_valid"}, 64'(imem_req_valid), 64'(eReqV));
        checkOutput({tag, " req_addr"},  imem_req_addr, eAddr);
        checkOutput({tag, " id_valid"},  64'(id_valid), 64'(eIdV));
        checkOutput({tag, " id_inst"},   64'(id_inst), 64'(eInst));
        checkOutput({tag, " id_pc"},     id_pc, ePc);
        checkOutput({tag, " fetch_cnt"}, fetch_cnt, eCnt);
    endtask

    // Holds reset for one cycle and checks the reset outputs. The task returns
    // just after the edge that leaves reset, so the DUT is then in its IDLE cycle.
    task automatic doReset();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
        rst = 1'b1;
        @(negedge clk);
        checkAll("reset", 1'b0, RST_PC, 1'b0, NOP, RST_PC, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    localparam logic [31:0] D0   = 32'h0010_0093;
    localparam logic [31:0] D4   = 32'h0020_0113;
    localparam logic [31:0] D8   = 32'h0030_0193;
    localparam logic [31:0] DC   = 32'h0040_0213;
    localparam logic [31:0] D300 = 32'h0050_0293;

    // Main test sequence.
    initial begin
        logic [63:0] expPc;
        logic [63:0] modelCnt;
        logic        memBusy;
        logic [63:0] memAddr;
        int          memWait;
        logic        acceptPending;
        logic [63:0] acceptAddr;
        logic        stallPrev;
        logic [63:0] stallAddr;
        int          since;
        logic        rRespV;
        logic [31:0] rRespD;
        logic        rRedV;
        logic [63:0] rRedPc;

        // Cycle-by-cycle table from the IDLE cycle after reset:
        // rr, respV, respD, idr, redV, redPc | reqV, addr, idV, inst, pc, cnt
        vecs[0]  = '{1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 64'h0,  1'b0, 64'h8000_0000, 1'b0, NOP,  64'h8000_0000, 64'd0};
        vecs[1]  = '{1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 64'h0,  1'b1, 64'h8000_0000, 1'b0, NOP,  64'h8000_0000, 64'd0};
        vecs[2]  = '{1'b1, 1'b1, D0,    1'b1, 1'b0, 64'h0,  1'b0, 64'h8000_0000, 1'b0, NOP,  64'h8000_0000, 64'd0};
        vecs[3]  = '{1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 64'h0,  1'b0, 64'h8000_0000, 1'b1, D0,   64'h8000_0000, 64'd0};
        vecs[4]  = '{1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 64'h0,  1'b1, 64'h8000_0004, 1'b0, D0,   64'h8000_0000, 64'd1};
        vecs[5]  = '{1'b1, 1'b1, D4,    1'b1, 1'b0, 64'h0,  1'b0, 64'h8000_0004, 1'b0, D0,   64'h8000_0000, 64'd1};
        vecs[6]  = '{1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 64'h0,  1'b0, 64'h8000_0004, 1'b1, D4,   64'h8000_0004, 64'd1};
        vecs[7]  = '{1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 64'h0,  1'b1, 64'h8000_0008, 1'b0, D4,   64'h8000_0004, 64'd2};
        vecs[8]  = '{1'b1, 1'b1, D8,    1'b1, 1'b0, 64'h0,  1'b0, 64'h8000_0008, 1'b0, D4,   64'h8000_0004, 64'd2};
        vecs[9]  = '{1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 64'h0,  1'b0, 64'h8000_0008, 1'b1, D8,   64'h8000_0008, 64'd2};
        vecs[10] = '{1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 64'h0,  1'b1, 64'h8000_000C, 1'b0, D8,   64'h8000_0008, 64'd3};
        vecs[11] = '{1'b1, 1'b1, DC,    1'b1, 1'b0, 64'h0,  1'b0, 64'h8000_000C, 1'b0, D8,   64'h8000_0008, 64'd3};
        vecs[12] = '{1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 64'h8000_0302, 1'b0, 64'h8000_000C, 1'b1, DC, 64'h8000_000C, 64'd3};
        vecs[13] = '{1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 64'h0,  1'b1, 64'h8000_0300, 1'b0, DC,   64'h8000_000C, 64'd4};
        vecs[14] = '{1'b1, 1'b1, D300,  1'b1, 1'b0, 64'h0,  1'b0, 64'h8000_0300, 1'b0, DC,   64'h8000_000C, 64'd4};
        vecs[15] = '{1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 64'h8000_0400, 1'b0, 64'h8000_0300, 1'b1, D300, 64'h8000_0300, 64'd4};
        vecs[16] = '{1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 64'h0,  1'b1, 64'h8000_0400, 1'b0, D300, 64'h8000_0300, 64'd4};

        doReset();
        for (int i = 0; i < 17; i++) begin
            applyStimulus(vecs[i].rr, vecs[i].respV, vecs[i].respD, vecs[i].idr, vecs[i].redV, vecs[i].redPc);
            @(negedge clk);
            checkAll($sformatf("vec%0d", i), vecs[i].expReqV, vecs[i].expAddr, vecs[i].expIdV,
                     vecs[i].expInst, vecs[i].expPc, vecs[i].expCnt);
            nextCycle();
        end

        // Decode stalls for 5 cycles in OUT: the output holds and no new request is made.
        doReset();
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
        nextCycle();
        nextCycle();
        applyStimulus(1'b1, 1'b1, 32'h1234_5677, 1'b0, 1'b0, 64'h0);
        nextCycle();
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
            @(negedge clk);
            checkOutput("stall id_valid", 64'(id_valid), 64'd1);
            checkOutput("stall id_inst", 64'(id_inst), 64'h1234_5677);
            checkOutput("stall id_pc", id_pc, RST_PC);
            checkOutput("stall req_valid", 64'(imem_req_valid), 64'd0);
            nextCycle();
        end
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 64'h0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
        @(negedge clk);
        checkOutput("release req_valid", 64'(imem_req_valid), 64'd1);
        checkOutput("release req_addr", imem_req_addr, 64'h8000_0004);
        checkOutput("release fetch_cnt", fetch_cnt, 64'd1);

        // The request is back-pressured for 4 cycles, with a redirect in the 2nd cycle.
        doReset();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
        nextCycle();
        for (int k = 1; k <= 4; k++) begin
            applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, (k == 2), 64'h8000_0100);
            @(negedge clk);
            checkOutput("bp req_valid", 64'(imem_req_valid), 64'd1);
            checkOutput("bp req_addr", imem_req_addr, RST_PC);
            nextCycle();
        end
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 64'h0);
        @(negedge clk);
        checkOutput("bp accept addr", imem_req_addr, RST_PC);
        nextCycle();
        applyStimulus(1'b0, 1'b1, 32'hDEAD_BEE3, 1'b1, 1'b0, 64'h0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 64'h0);
        @(negedge clk);
        checkOutput("bp drop id_valid", 64'(id_valid), 64'd0);
        checkOutput("bp drop id_inst", 64'(id_inst), 64'(NOP));
        checkOutput("bp new req_valid", 64'(imem_req_valid), 64'd1);
        checkOutput("bp new req_addr", imem_req_addr, 64'h8000_0100);

        // A redirect arrives in WAIT, and the response comes 2 cycles later.
        doReset();
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 64'h0);
        nextCycle();
        nextCycle();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 64'h8000_0200);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 64'h0);
        @(negedge clk);
        checkOutput("wait-redir id_valid a", 64'(id_valid), 64'd0);
        nextCycle();
        applyStimulus(1'b0, 1'b1, 32'hBAD0_0013, 1'b1, 1'b0, 64'h0);
        @(negedge clk);
        checkOutput("wait-redir id_valid b", 64'(id_valid), 64'd0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 64'h0);
        @(negedge clk);
        checkAll("wait-redir", 1'b1, 64'h8000_0200, 1'b0, NOP, RST_PC, 64'd0);

        // Reset arrives mid-fetch in WAIT, and a stale response follows the deassertion.
        doReset();
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 64'h0);
        nextCycle();
        nextCycle();
        applyStimulus(1'b1, 1'b1, 32'h0AAA_0013, 1'b1, 1'b0, 64'h0);
        nextCycle();
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 64'h0);
        @(negedge clk);
        checkOutput("pre-rst id_valid", 64'(id_valid), 64'd1);
        nextCycle();
        nextCycle();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 64'h0);
        rst = 1'b1;
        #1;
        checkAll("async rst", 1'b0, RST_PC, 1'b0, NOP, RST_PC, 64'd0);
        nextCycle();
        rst = 1'b0;
        applyStimulus(1'b1, 1'b1, 32'h0BBB_0013, 1'b1, 1'b0, 64'h0);
        @(negedge clk);
        checkOutput("stale idle req_valid", 64'(imem_req_valid), 64'd0);
        checkOutput("stale idle id_valid", 64'(id_valid), 64'd0);
        nextCycle();
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 64'h0);
        @(negedge clk);
        checkOutput("post-rst req_valid", 64'(imem_req_valid), 64'd1);
        checkOutput("post-rst req_addr", imem_req_addr, RST_PC);
        nextCycle();
        applyStimulus(1'b0, 1'b1, 32'h0CCC_0013, 1'b1, 1'b0, 64'h0);
        @(negedge clk);
        checkOutput("post-rst wait id_valid", 64'(id_valid), 64'd0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
        @(negedge clk);
        checkOutput("post-rst deliver inst", 64'(id_inst), 64'h0CCC_0013);
        checkOutput("post-rst deliver pc", id_pc, RST_PC);
        checkOutput("post-rst deliver cnt", fetch_cnt, 64'd0);

        // Randomized phase. The model tracks program order: every instruction
        // decode takes must come from the next expected PC. An accepted take moves
        // that PC on by 4, and a redirect in the same cycle overrides it.
        doReset();
        expPc         = RST_PC;
        modelCnt      = 64'd0;
        memBusy       = 1'b0;
        memAddr       = 64'h0;
        memWait       = 0;
        acceptPending = 1'b0;
        acceptAddr    = 64'h0;
        stallPrev     = 1'b0;
        stallAddr     = 64'h0;
        since         = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (acceptPending) begin
                checkOutput("one outstanding", 64'(memBusy), 64'd0);
                memBusy       = 1'b1;
                memAddr       = acceptAddr;
                memWait       = $urandom_range(0, 2);
                acceptPending = 1'b0;
            end
            rRespV = 1'b0;
            rRespD = $urandom;
            if (memBusy) begin
                if (memWait == 0) begin
                    rRespV  = 1'b1;
                    rRespD  = instFor(memAddr);
                    memBusy = 1'b0;
                end else begin
                    memWait--;
                end
            end
            rRedV  = ($urandom_range(0, 99) < 8);
            rRedPc = 64'h8000_0000 + 64'($urandom_range(0, 1023));
            applyStimulus(($urandom_range(0, 3) != 0), rRespV, rRespD,
                          ($urandom_range(0, 9) < 7), rRedV, rRedPc);
            @(negedge clk);
            checkOutput("rnd fetch_cnt", fetch_cnt, modelCnt);
            if (imem_req_valid) begin
                checkOutput("rnd addr align", 64'(imem_req_addr[1:0]), 64'd0);
            end
            if (stallPrev) begin
                checkOutput("rnd hold valid", 64'(imem_req_valid), 64'd1);
                checkOutput("rnd hold addr", imem_req_addr, stallAddr);
            end
            stallPrev = imem_req_valid && !imem_req_ready;
            stallAddr = imem_req_addr;
            if (id_valid && id_ready) begin
                checkOutput("rnd deliver pc", id_pc, expPc);
                checkOutput("rnd deliver inst", 64'(id_inst), 64'(instFor(expPc)));
                modelCnt = modelCnt + 64'd1;
                expPc    = expPc + 64'd4;
                since    = 0;
            end else begin
                since++;
            end
            if (redirect_valid) begin
                expPc = {redirect_pc[63:2], 2'b00};
            end
            if (imem_req_valid && imem_req_ready) begin
                acceptPending = 1'b1;
                acceptAddr    = imem_req_addr;
            end
            if (since > 200) begin
                assertCount++;
                failCount++;
                $display("[TB] FAIL rnd progress: %0d cycles without a delivery, required at most 200", since);
                break;
            end
            nextCycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
